// File: rtl/gpio_filt_pkg.sv
// Shared constants and types for the GPIO input conditioning stage.
// Imported by the per-pin filter and the top.
package gpio_filt_pkg;

  localparam int unsigned GpioFiltDefaultCntW = 16;
  localparam int unsigned GpioFiltMinSync = 2;
  localparam int unsigned GpioFiltMaxSync = 4;

  typedef logic [GpioFiltDefaultCntW-1:0] gpio_filt_cnt_t;

endpackage

// File: rtl/gpio_filter_bit.sv
// Per-pin glitch filter: output level only follows the synchronized
// input once it has disagreed for thr consecutive cycles.
module gpio_filter_bit
  import gpio_filt_pkg::*;
#(
  parameter int unsigned CntWidth = GpioFiltDefaultCntW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                s_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] thr_i,
  output logic                q_o
);

  logic                q_q, q_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth:0]   cnt_inc;
  logic                hit;

  // One extra bit so the compare cannot be fooled by a wrap.
  assign cnt_inc = {1'b0, cnt_q} + (CntWidth+1)'(1);
  assign hit     = cnt_inc >= {1'b0, thr_i};

  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    unique case (1'b1)
      !en_i:                          q_d = s_i;
      en_i && (s_i == q_q):           cnt_d = '0;
      en_i && (s_i != q_q) && hit:    q_d = s_i;
      default:                        cnt_d = cnt_inc[CntWidth-1:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO pad input conditioning: synchronizer, optional per-pin glitch
// filter, and one-cycle rise/fall pulses on the conditioned level.
module gpio_in_filter
  import gpio_filt_pkg::*;
#(
  parameter int unsigned NumPins    = 32,
  parameter int unsigned CntWidth   = GpioFiltDefaultCntW,
  parameter int unsigned SyncStages = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPins-1:0]  gpio_i,
  input  logic [NumPins-1:0]  filter_en_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic [NumPins-1:0]  gpio_o,
  output logic [NumPins-1:0]  rise_o,
  output logic [NumPins-1:0]  fall_o,
  output logic                chg_o
);

  if (SyncStages < GpioFiltMinSync || SyncStages > GpioFiltMaxSync) begin : g_bad_sync
    $error("gpio_in_filter: SyncStages must be 2..4");
  end

  logic [NumPins-1:0]  sync_q [SyncStages];
  logic [NumPins-1:0]  sync_s;
  logic [NumPins-1:0]  filt_q;
  logic [NumPins-1:0]  dly_q;
  logic [CntWidth-1:0] thr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SyncStages-1];

  // Threshold is taken live; zero behaves as one.
  assign thr = (thresh_i == '0) ? CntWidth'(1) : thresh_i;

  for (genvar g = 0; g < NumPins; g++) begin : g_pin
    gpio_filter_bit #(
      .CntWidth (CntWidth)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .s_i    (sync_s[g]),
      .en_i   (filter_en_i[g]),
      .thr_i  (thr),
      .q_o    (filt_q[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dly_q <= '0;
    else         dly_q <= filt_q;
  end

  assign gpio_o = filt_q;
  assign rise_o = filt_q & ~dly_q;
  assign fall_o = ~filt_q & dly_q;
  assign chg_o  = |(rise_o | fall_o);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Bench for gpio_in_filter: directed vector table, reset corner cases
// and randomized traffic against a sliding-window reference model.
module tb_gpio_in_filter;

  localparam int NP = 32;
  localparam int CW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] gpio, en;
  logic [CW-1:0] th;
  logic [NP-1:0] gpio_o, rise_o, fall_o;
  logic          chg_o;

  always #5 clk = ~clk;

  gpio_in_filter #(
    .NumPins    (NP),
    .CntWidth   (CW),
    .SyncStages (SS)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .gpio_i      (gpio),
    .filter_en_i (en),
    .thresh_i    (th),
    .gpio_o      (gpio_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .chg_o       (chg_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: pad delay line, history of synchronized samples, levels.
  logic [NP-1:0] m_pipe [SS];
  logic [NP-1:0] m_hist [64];
  logic [NP-1:0] m_q, m_d;

  typedef struct {
    logic [NP-1:0] g;
    logic [NP-1:0] en;
    logic [CW-1:0] th;
    int            n;
    logic [NP-1:0] eg;
    logic [NP-1:0] er;
    logic [NP-1:0] ef;
    logic          ec;
  } vec_t;

  vec_t tv [25];

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic outs_chk(input string nm, input logic [NP-1:0] eg,
                          input logic [NP-1:0] er, input logic [NP-1:0] ef,
                          input logic ec);
    chk(nm, {gpio_o, rise_o, fall_o, chg_o}, {eg, er, ef, ec});
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_pipe[k] = '0;
    for (int j = 0; j < 64; j++) m_hist[j] = '0;
    m_q = '0;
    m_d = '0;
  endtask

  // A filtered pin takes the new level once the last thr samples
  // all differ from the current level.
  task automatic model_step(input logic [NP-1:0] g, input logic [NP-1:0] e,
                            input logic [CW-1:0] t);
    logic [NP-1:0] s, qn;
    int thr;
    bit ok;
    s   = m_pipe[SS-1];
    thr = (t == 0) ? 1 : int'(t);
    for (int j = 63; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = s;
    for (int i = 0; i < NP; i++) begin
      if (!e[i]) qn[i] = s[i];
      else begin
        ok = 1'b1;
        for (int j = 0; j < thr; j++)
          if (m_hist[j][i] == m_q[i]) ok = 1'b0;
        qn[i] = ok ? s[i] : m_q[i];
      end
    end
    m_d = m_q;
    m_q = qn;
    for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = g;
  endtask

  task automatic tick();
    logic [NP-1:0] g0, e0;
    logic [CW-1:0] t0;
    logic [NP-1:0] mr, mf;
    g0 = gpio;
    e0 = en;
    t0 = th;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(g0, e0, t0);
    #1;
    mr = m_q & ~m_d;
    mf = ~m_q & m_d;
    chk("model", {gpio_o, rise_o, fall_o, chg_o}, {m_q, mr, mf, |(mr | mf)});
  endtask

  initial begin
    tv[0]  = '{32'h00, 32'h0, 16'd0,  4,  32'h00, 32'h00, 32'h00, 1'b0};
    tv[1]  = '{32'h20, 32'h0, 16'd0,  2,  32'h00, 32'h00, 32'h00, 1'b0};
    tv[2]  = '{32'h20, 32'h0, 16'd0,  1,  32'h20, 32'h20, 32'h00, 1'b1};
    tv[3]  = '{32'h20, 32'h0, 16'd0,  1,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[4]  = '{32'h28, 32'h8, 16'd10, 11, 32'h20, 32'h00, 32'h00, 1'b0};
    tv[5]  = '{32'h28, 32'h8, 16'd10, 1,  32'h28, 32'h08, 32'h00, 1'b1};
    tv[6]  = '{32'h28, 32'h8, 16'd10, 1,  32'h28, 32'h00, 32'h00, 1'b0};
    tv[7]  = '{32'h20, 32'h8, 16'd10, 11, 32'h28, 32'h00, 32'h00, 1'b0};
    tv[8]  = '{32'h20, 32'h8, 16'd10, 1,  32'h20, 32'h00, 32'h08, 1'b1};
    tv[9]  = '{32'h28, 32'h8, 16'd10, 9,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[10] = '{32'h20, 32'h8, 16'd10, 20, 32'h20, 32'h00, 32'h00, 1'b0};
    tv[11] = '{32'h28, 32'h8, 16'd10, 10, 32'h20, 32'h00, 32'h00, 1'b0};
    tv[12] = '{32'h20, 32'h8, 16'd10, 1,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[13] = '{32'h20, 32'h8, 16'd10, 1,  32'h28, 32'h08, 32'h00, 1'b1};
    tv[14] = '{32'h20, 32'h8, 16'd10, 20, 32'h20, 32'h00, 32'h00, 1'b0};
    tv[15] = '{32'h28, 32'h8, 16'd0,  2,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[16] = '{32'h28, 32'h8, 16'd0,  1,  32'h28, 32'h08, 32'h00, 1'b1};
    tv[17] = '{32'h20, 32'h8, 16'd0,  3,  32'h20, 32'h00, 32'h08, 1'b1};
    tv[18] = '{32'h28, 32'h8, 16'd20, 8,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[19] = '{32'h28, 32'h8, 16'd4,  1,  32'h28, 32'h08, 32'h00, 1'b1};
    tv[20] = '{32'h20, 32'h8, 16'd4,  5,  32'h28, 32'h00, 32'h00, 1'b0};
    tv[21] = '{32'h20, 32'h8, 16'd4,  1,  32'h20, 32'h00, 32'h08, 1'b1};
    tv[22] = '{32'h28, 32'h8, 16'd10, 5,  32'h20, 32'h00, 32'h00, 1'b0};
    tv[23] = '{32'h28, 32'h0, 16'd10, 1,  32'h28, 32'h08, 32'h00, 1'b1};
    tv[24] = '{32'h20, 32'h0, 16'd10, 3,  32'h20, 32'h00, 32'h08, 1'b1};

    rst_n = 1'b0;
    gpio  = '1;
    en    = '0;
    th    = '0;
    model_reset();
    #1;
    outs_chk("reset_async", '0, '0, '0, 1'b0);
    repeat (3) tick();
    outs_chk("in_reset", '0, '0, '0, 1'b0);
    #2 rst_n = 1'b1;
    repeat (2) tick();
    outs_chk("rel_edge2", '0, '0, '0, 1'b0);
    tick();
    outs_chk("rel_edge3", '1, '1, '0, 1'b1);
    tick();
    outs_chk("rel_edge4", '1, '0, '0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      gpio = tv[i].g;
      en   = tv[i].en;
      th   = tv[i].th;
      repeat (tv[i].n) tick();
      outs_chk($sformatf("vec%0d", i), tv[i].eg, tv[i].er, tv[i].ef, tv[i].ec);
    end

    gpio = 32'h28;
    en   = 32'h8;
    th   = 16'd10;
    repeat (7) tick();
    outs_chk("mid_pre", 32'h20, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    outs_chk("mid_async", '0, '0, '0, 1'b0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (11) tick();
    outs_chk("mid_restart11", 32'h20, '0, '0, 1'b0);
    tick();
    outs_chk("mid_restart12", 32'h28, 32'h08, '0, 1'b1);

    for (int c = 0; c < 400; c++) begin
      if (c % 8 == 0) begin
        en = $urandom;
        th = CW'($urandom_range(0, 6));
      end
      gpio = gpio ^ ($urandom & $urandom & $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
